// File: rtl/gp9001_pkg.sv
// Shared definitions for the GP9001 CPU-side command port.
// Holds the FSM state encoding, the one-hot operation bit positions,
// default geometry constants and a one-hot legality helper.
package gp9001_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // Bit positions of the operation strobes inside the packed op vector.
  localparam int OP_W            = 6;
  localparam int OPB_SELECT_REG  = 0;
  localparam int OPB_WRITE_REG   = 1;
  localparam int OPB_WRITE_RAM   = 2;
  localparam int OPB_READ_RAM_H  = 3;
  localparam int OPB_READ_RAM_L  = 4;
  localparam int OPB_SET_RAM_PTR = 5;

  localparam int DEF_VRAM_AW = 14;
  localparam int DEF_NREGS   = 16;

  // True when exactly one strobe is set.
  function automatic logic op_onehot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - 6'd1)) == '0);
  endfunction

endpackage

// File: rtl/gp9001_regfile.sv
// Control register file (NREGS x 16) plus the 8-bit register select.
// Latency: select/write land on the clock edge after the enable; o_reg_wstb
// pulses for one cycle alongside the landed write. No backpressure.
// Ports: i_clk/i_rst_n, i_sel_we/i_sel_din (select load), i_wr_en/i_wr_data
// (write to selected reg), o_regs (flattened, reg n at [16n+15:16n]), o_reg_wstb.
module gp9001_regfile
  import gp9001_pkg::*;
#(
  parameter int NREGS = DEF_NREGS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sel_we,
  input  logic [7:0]            i_sel_din,
  input  logic                  i_wr_en,
  input  logic [15:0]           i_wr_data,
  output logic [16*NREGS-1:0]   o_regs,
  output logic                  o_reg_wstb
);

  localparam int IW = $clog2(NREGS);

  logic [7:0]  r_sel;
  logic [15:0] r_regs [NREGS];
  logic        w_hit;

  // Writes to an index beyond the file are dropped without a strobe.
  assign w_hit = i_wr_en && ({24'd0, r_sel} < 32'(NREGS));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel      <= '0;
      o_reg_wstb <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (i_sel_we) r_sel <= i_sel_din;
      o_reg_wstb <= w_hit;
      if (w_hit) r_regs[r_sel[IW-1:0]] <= i_wr_data;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign o_regs[16*g +: 16] = r_regs[g];
  end

endmodule

// File: rtl/garegga_gp9001_cpu_port.sv
// GP9001 CPU command responder: decodes one-hot op strobes on a CS rising
// edge, owns the VRAM pointer, arbitrates single-word VRAM accesses.
// Latency from CS-rise sample edge: reg/sel/ptr ops ACK at +1, VRAM write +2,
// VRAM read +3; each cycle without VRAM_GNT adds one. VRAM_GNT is the only stall.
// Ports: CPU side CS/OP_*/DIN/DOUT/ACK; VRAM side ADDR/WDATA/WE/RD/GNT/RDATA;
// REGS/REG_WSTB to scroll logic. Optional OPERR sticky flag when
// GARREGGA_GP9001_OPERR_EN is defined.
module garegga_gp9001_cpu_port
  import gp9001_pkg::*;
#(
  parameter int VRAM_AW = DEF_VRAM_AW,
  parameter int NREGS   = DEF_NREGS
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CS,
  input  logic                  OP_SELECT_REG,
  input  logic                  OP_WRITE_REG,
  input  logic                  OP_WRITE_RAM,
  input  logic                  OP_READ_RAM_H,
  input  logic                  OP_READ_RAM_L,
  input  logic                  OP_SET_RAM_PTR,
  input  logic [15:0]           DIN,
  output logic [15:0]           DOUT,
  output logic                  ACK,
  output logic [VRAM_AW-1:0]    VRAM_ADDR,
  output logic [15:0]           VRAM_WDATA,
  output logic                  VRAM_WE,
  output logic                  VRAM_RD,
  input  logic                  VRAM_GNT,
  input  logic [15:0]           VRAM_RDATA,
  output logic [16*NREGS-1:0]   REGS,
  output logic                  REG_WSTB
`ifdef GARREGGA_GP9001_OPERR_EN
  ,
  output logic                  OPERR
`endif
);

  state_t              r_state, w_next;
  logic                r_cs, r_cs_prev;
  logic [OP_W-1:0]     r_op, w_op_in;
  logic [15:0]         r_din;
  logic [VRAM_AW-1:0]  r_ptr;
  logic [15:0]         r_wdata, r_dout;
  logic                r_is_wr, r_is_rdl;
  logic                w_start, w_illegal;
  logic                w_sel_we, w_reg_we, w_ptr_load, w_ptr_inc, w_dout_load, w_kind_load;

  assign w_op_in[OPB_SELECT_REG]  = OP_SELECT_REG;
  assign w_op_in[OPB_WRITE_REG]   = OP_WRITE_REG;
  assign w_op_in[OPB_WRITE_RAM]   = OP_WRITE_RAM;
  assign w_op_in[OPB_READ_RAM_H]  = OP_READ_RAM_H;
  assign w_op_in[OPB_READ_RAM_L]  = OP_READ_RAM_L;
  assign w_op_in[OPB_SET_RAM_PTR] = OP_SET_RAM_PTR;

  // CS, strobes and data are sampled together; the operation starts one
  // edge later from the sampled copy so strobe/data skew cannot matter.
  assign w_start   = (r_state == ST_IDLE) && r_cs && !r_cs_prev;
  assign w_illegal = !op_onehot(r_op);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_sel_we    = 1'b0;
    w_reg_we    = 1'b0;
    w_ptr_load  = 1'b0;
    w_ptr_inc   = 1'b0;
    w_dout_load = 1'b0;
    w_kind_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next = ST_ACK;
          if (!w_illegal) begin
            if (r_op[OPB_SELECT_REG])       w_sel_we   = 1'b1;
            else if (r_op[OPB_WRITE_REG])   w_reg_we   = 1'b1;
            else if (r_op[OPB_SET_RAM_PTR]) w_ptr_load = 1'b1;
            else begin
              // Remaining legal ops all touch VRAM.
              w_kind_load = 1'b1;
              w_next      = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (VRAM_GNT) begin
          if (r_is_wr) begin
            w_ptr_inc = 1'b1;
            w_next    = ST_ACK;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        w_dout_load = 1'b1;
        w_ptr_inc   = r_is_rdl;
        w_next      = ST_ACK;
      end
      ST_ACK: begin
        if (!CS) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cs      <= 1'b0;
      r_cs_prev <= 1'b0;
      r_op      <= '0;
      r_din     <= '0;
      r_ptr     <= '0;
      r_wdata   <= '0;
      r_dout    <= '0;
      r_is_wr   <= 1'b0;
      r_is_rdl  <= 1'b0;
    end else begin
      r_cs      <= CS;
      r_cs_prev <= r_cs;
      r_op      <= w_op_in;
      r_din     <= DIN;
      if (w_ptr_load)     r_ptr <= r_din[VRAM_AW-1:0];
      else if (w_ptr_inc) r_ptr <= r_ptr + VRAM_AW'(1);
      if (w_kind_load) begin
        r_is_wr  <= r_op[OPB_WRITE_RAM];
        r_is_rdl <= r_op[OPB_READ_RAM_L];
        if (r_op[OPB_WRITE_RAM]) r_wdata <= r_din;
      end
      if (w_dout_load) r_dout <= VRAM_RDATA;
    end
  end

  assign ACK        = (r_state == ST_ACK);
  assign VRAM_WE    = (r_state == ST_REQ) &&  r_is_wr;
  assign VRAM_RD    = (r_state == ST_REQ) && !r_is_wr;
  assign VRAM_ADDR  = r_ptr;
  assign VRAM_WDATA = r_wdata;
  assign DOUT       = r_dout;

  gp9001_regfile #(.NREGS(NREGS)) u_regfile (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_sel_we   (w_sel_we),
    .i_sel_din  (r_din[7:0]),
    .i_wr_en    (w_reg_we),
    .i_wr_data  (r_din),
    .o_regs     (REGS),
    .o_reg_wstb (REG_WSTB)
  );

`ifdef GARREGGA_GP9001_OPERR_EN
  logic r_operr;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                  r_operr <= 1'b0;
    else if (w_start && w_illegal) r_operr <= 1'b1;
  end
  assign OPERR = r_operr;
`endif

endmodule
